// File: rtl/fpgapu_audio_pkg.sv
// Shared audio constants and sample-format helpers for the audio sinks.
// Samples arrive as unsigned offset-binary; DAC slots expect left-justified two's complement.
package fpgapu_audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 9;
    localparam int I2S_SLOT_WIDTH     = 16;
    localparam int I2S_WORD_MAX_W     = 32;

    // Flipping the MSB turns offset-binary into two's complement; the shift left-justifies with zero fill.
    function automatic logic [I2S_WORD_MAX_W-1:0] to_i2s_word(
        input logic [I2S_WORD_MAX_W-1:0] sample,
        input int                        sample_w,
        input int                        slot_w
    );
        logic [I2S_WORD_MAX_W-1:0] signed_val;
        signed_val = sample ^ (I2S_WORD_MAX_W'(1) << (sample_w - 1));
        return signed_val << (slot_w - sample_w);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: toggles o_bclk every CLK_DIV system clocks and flags
// the cycle in which BCLK is about to fall.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bclk,
    output logic o_fall_tick
);

    localparam int                DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             at_tc;

    assign at_tc       = (div_cnt == DIV_TC);
    assign o_fall_tick = at_tc & o_bclk;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            o_bclk  <= 1'b0;
        end else if (at_tc) begin
            div_cnt <= '0;
            o_bclk  <= ~o_bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// Mono I2S transmitter: one-entry holding register feeding a Philips-format
// serialiser that sends each sample in both the left and right slots.
module i2s_audio_tx
    import fpgapu_audio_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_sample_valid,
    output logic                    o_sample_ready,
    output logic                    o_bclk,
    output logic                    o_lrclk,
    output logic                    o_sd,
    output logic                    o_underrun
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int K_W        = $clog2(FRAME_BITS);
    localparam int IDX_W      = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    localparam logic [K_W-1:0]          K_LAST   = K_W'(FRAME_BITS - 1);
    localparam logic [K_W-1:0]          K_RIGHT  = K_W'(SLOT_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic                    fall_tick;
    logic [K_W-1:0]          bit_cnt;
    logic [K_W-1:0]          bit_cnt_nxt;
    logic [K_W-1:0]          pos_in_slot;
    logic [IDX_W-1:0]        sd_idx;
    logic [SLOT_WIDTH-1:0]   cur_word;
    logic [SAMPLE_WIDTH-1:0] cur_sample;
    logic [SAMPLE_WIDTH-1:0] hold_data;
    logic                    hold_full;
    logic                    frame_load;
    logic                    xfer;
    logic                    lrclk_nxt;
    logic                    sd_nxt;

    i2s_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_bclk     (o_bclk),
        .o_fall_tick(fall_tick)
    );

    assign o_sample_ready = ~hold_full;
    assign xfer           = i_sample_valid & ~hold_full;

    always_comb begin
        bit_cnt_nxt = (bit_cnt == K_LAST) ? '0 : bit_cnt + 1'b1;
        frame_load  = fall_tick && (bit_cnt_nxt == '0);
        lrclk_nxt   = (bit_cnt_nxt >= K_RIGHT);
        cur_word    = SLOT_WIDTH'(to_i2s_word(I2S_WORD_MAX_W'(cur_sample), SAMPLE_WIDTH, SLOT_WIDTH));
        // The bit driven on entering k+1 is word position k (one-BCLK I2S delay),
        // so the current counter value directly indexes the frame word.
        pos_in_slot = (bit_cnt >= K_RIGHT) ? bit_cnt - K_RIGHT : bit_cnt;
        sd_idx      = IDX_W'(SLOT_WIDTH - 1) - IDX_W'(pos_in_slot);
        sd_nxt      = cur_word[sd_idx];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt    <= K_LAST;
            o_lrclk    <= 1'b0;
            o_sd       <= 1'b0;
            o_underrun <= 1'b0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            cur_sample <= MIDSCALE;
        end else begin
            o_underrun <= 1'b0;
            if (fall_tick) begin
                bit_cnt <= bit_cnt_nxt;
                o_lrclk <= lrclk_nxt;
                o_sd    <= sd_nxt;
            end
            if (frame_load && hold_full) begin
                cur_sample <= hold_data;
                hold_full  <= 1'b0;
            end else begin
                // Empty at frame start: repeat the last sample; a same-cycle
                // transfer is still captured for the following frame.
                if (frame_load) begin
                    o_underrun <= 1'b1;
                end
                if (xfer) begin
                    hold_data <= i_sample;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a time-based frame model predicts every
// output each cycle and reassembles slot words at BCLK rising edges.
module tb_i2s_audio_tx;

    localparam int CLK_DIV   = 4;
    localparam int SLOT      = 16;
    localparam int FRAME     = 2 * SLOT;
    localparam int BCLK_CYC  = 2 * CLK_DIV;
    localparam int FRAME_CYC = BCLK_CYC * FRAME;

    logic       i_clk;
    logic       i_rst_n;
    logic [8:0] i_sample;
    logic       i_sample_valid;
    logic       o_sample_ready;
    logic       o_bclk;
    logic       o_lrclk;
    logic       o_sd;
    logic       o_underrun;

    int          checks;
    int          failures;
    int          t;
    logic        m_full;
    logic [8:0]  m_hold;
    logic [8:0]  m_cur;
    logic [15:0] prev_word;
    logic [15:0] acc;

    i2s_audio_tx #(
        .CLK_DIV     (CLK_DIV),
        .SAMPLE_WIDTH(9),
        .SLOT_WIDTH  (SLOT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_sample      (i_sample),
        .i_sample_valid(i_sample_valid),
        .o_sample_ready(o_sample_ready),
        .o_bclk        (o_bclk),
        .o_lrclk       (o_lrclk),
        .o_sd          (o_sd),
        .o_underrun    (o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "watchdog");
    end

    // Offset-binary to signed is "add half the range modulo the range"; then scale to the slot MSBs.
    function automatic logic [15:0] ref_word(input logic [8:0] s);
        int v;
        v = (int'(s) + 256) % 512;
        return 16'(v * 128);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0d", tag, obs, expv, t);
        end
    endtask

    task automatic step(input logic v, input logic [8:0] d);
        logic        xfer;
        logic        exp_un;
        logic        e_lr;
        logic        e_sd;
        logic [15:0] w;
        int          falls;
        int          k;
        i_sample_valid = v;
        i_sample       = d;
        xfer   = v && !m_full;
        exp_un = 1'b0;
        t++;
        if (t % FRAME_CYC == BCLK_CYC) begin
            prev_word = ref_word(m_cur);
            if (m_full) begin
                m_cur  = m_hold;
                m_full = 1'b0;
            end else begin
                exp_un = 1'b1;
            end
        end
        if (xfer) begin
            m_hold = d;
            m_full = 1'b1;
        end
        @(posedge i_clk);
        #1;
        falls = t / BCLK_CYC;
        if (falls == 0) begin
            e_lr = 1'b0;
            e_sd = 1'b0;
            k    = 0;
        end else begin
            k    = (falls - 1) % FRAME;
            e_lr = (k >= SLOT);
            if (k == 0) begin
                e_sd = prev_word[0];
            end else begin
                w    = ref_word(m_cur);
                e_sd = w[SLOT - 1 - ((k - 1) % SLOT)];
            end
        end
        chk("bclk", o_bclk, (t / CLK_DIV) % 2);
        chk("lrclk", o_lrclk, e_lr);
        chk("sd", o_sd, e_sd);
        chk("ready", o_sample_ready, !m_full);
        chk("underrun", o_underrun, exp_un);
        if ((t % BCLK_CYC == CLK_DIV) && falls > 0) begin
            acc = {acc[14:0], o_sd};
            if (k == SLOT) chk("left_slot", acc, ref_word(m_cur));
            if (k == 0 && falls > 1) chk("right_slot", acc, prev_word);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'($urandom));
    endtask

    task automatic produce(input logic [8:0] d);
        logic accepted;
        int   waited;
        waited = 0;
        do begin
            accepted = !m_full;
            step(1'b1, d);
            waited++;
        end while (!accepted && waited < 2 * FRAME_CYC);
        chk("produce_accept", accepted, 1'b1);
    endtask

    task automatic advance_to(input int phase);
        int n;
        n = 0;
        while ((t % FRAME_CYC) != phase && n < FRAME_CYC) begin
            step(1'b0, 9'($urandom));
            n++;
        end
        chk("advance_phase", t % FRAME_CYC, phase);
    endtask

    task automatic do_reset();
        i_sample_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_bclk", o_bclk, 1'b0);
        chk("rst_lrclk", o_lrclk, 1'b0);
        chk("rst_sd", o_sd, 1'b0);
        chk("rst_ready", o_sample_ready, 1'b1);
        chk("rst_underrun", o_underrun, 1'b0);
        t         = 0;
        m_full    = 1'b0;
        m_hold    = '0;
        m_cur     = 9'h100;
        prev_word = '0;
        acc       = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        t              = 0;
        i_rst_n        = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        @(negedge i_clk);

        // Idle after reset: midscale frames, one underrun per frame.
        do_reset();
        idle(2 * FRAME_CYC + 100);

        // One full-scale sample before the first frame, then a producer stall.
        do_reset();
        step(1'b1, 9'h1FF);
        idle(3 * FRAME_CYC + 200);

        // Back-to-back producer with valid held high.
        produce(9'h000);
        produce(9'h0FF);
        produce(9'h180);
        for (int i = 0; i < 6; i++) produce(9'($urandom));
        idle(FRAME_CYC + 50);

        // Transfer lands exactly on the frame-load edge with the register empty.
        advance_to(BCLK_CYC - 1);
        step(1'b1, 9'h0AA);
        idle(2 * FRAME_CYC);

        // Sparse random producer; samples change freely while not ready.
        for (int i = 0; i < 5 * FRAME_CYC; i++)
            step($urandom_range(0, 99) < 2, 9'($urandom));

        // Reset in the middle of the right slot with a pending sample.
        produce(9'h123);
        produce(9'h055);
        advance_to(BCLK_CYC * 21 + 2);
        do_reset();
        idle(2 * FRAME_CYC + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
